// File: rtl/lc3_pipe_ctrl_if.sv
// Bus between the LC-3 pipeline controller and the datapath.
// master: the controller (consumes decode_out/status, drives enables and selects).
// slave : the datapath side (drives decode_out/status, consumes enables and selects).
interface lc3_pipe_ctrl_if;
   logic [15:0] IR;
   logic [15:0] IR_exec;
   logic [2:0]  nzp;
   logic        complete_instr;
   logic        complete_data;
   logic        enable_fetch;
   logic        enable_updatePC;
   logic        enable_decode;
   logic        enable_execute;
   logic        enable_writeback;
   logic [1:0]  mem_state;
   logic        br_taken;
   logic        bypass_alu_1;
   logic        bypass_alu_2;

   modport master (
      input  IR, IR_exec, nzp, complete_instr, complete_data,
      output enable_fetch, enable_updatePC, enable_decode, enable_execute,
             enable_writeback, mem_state, br_taken, bypass_alu_1, bypass_alu_2
   );

   modport slave (
      output IR, IR_exec, nzp, complete_instr, complete_data,
      input  enable_fetch, enable_updatePC, enable_decode, enable_execute,
             enable_writeback, mem_state, br_taken, bypass_alu_1, bypass_alu_2
   );
endinterface

// File: rtl/lc3_pipe_ctrl.sv
// LC-3 pipeline controller: pipeline fill, data-memory access sequencing,
// branch resolution with bubble insertion, instruction-fetch stalls and ALU bypass.
// Ports:
//   clock, reset  - pipeline clock, synchronous active-high reset
//   bus (master)  - IR, IR_exec, nzp, complete_instr, complete_data in;
//                   stage enables, mem_state, br_taken, bypass_alu_1/2 out
// Stage enables, br_taken and bypass selects are decoded from the controller
// state and the current-cycle handshakes; mem_state is the FSM register itself.
module lc3_pipe_ctrl #(
   parameter int unsigned BR_BUBBLES = 2
) (
   input  logic            clock,
   input  logic            reset,
   lc3_pipe_ctrl_if.master bus
);

   localparam int unsigned FILL_W = 2;
   localparam int unsigned BUB_W  = 2;
   localparam logic [BUB_W-1:0]  BUB_LOAD  = BUB_W'(BR_BUBBLES - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(3);

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;

   typedef enum logic [1:0] {
      MEM_READ  = 2'd0,
      MEM_IND   = 2'd1,
      MEM_WRITE = 2'd2,
      MEM_IDLE  = 2'd3
   } mem_state_t;

   mem_state_t        mem_state_q;
   logic [FILL_W-1:0] fill_q;
   logic [BUB_W-1:0]  bub_q;
   logic              exec_handled_q;
   logic              wb_prev_q;
   logic              ind_load_q;

   logic [3:0] exec_op;
   logic [3:0] dec_op;
   logic       exec_is_mem;
   logic       exec_is_ctrl;
   logic       exec_is_alu;
   logic       dec_is_alu;
   logic       dec_is_add_and;
   logic       detect_ok;
   logic       mem_start;
   logic       br_detect;

   logic en_fetch, en_update_pc, en_decode, en_execute, en_writeback;
   logic br_taken_c, bypass_1_c, bypass_2_c;

   // Fields of IR/IR_exec that play no part in hazard decisions.
   logic unused_ir_bits;
   assign unused_ir_bits = ^{bus.IR[11:9], bus.IR[4:3], bus.IR_exec[8:0]};

   // Opcode classification and event detection.
   always_comb begin
      exec_op        = bus.IR_exec[15:12];
      dec_op         = bus.IR[15:12];
      exec_is_mem    = (exec_op == OP_LD)  || (exec_op == OP_LDR) ||
                       (exec_op == OP_ST)  || (exec_op == OP_STR) ||
                       (exec_op == OP_LDI) || (exec_op == OP_STI);
      exec_is_ctrl   = (exec_op == OP_BR) || (exec_op == OP_JMP);
      exec_is_alu    = (exec_op == OP_ADD) || (exec_op == OP_AND) || (exec_op == OP_NOT);
      dec_is_add_and = (dec_op == OP_ADD) || (dec_op == OP_AND);
      dec_is_alu     = dec_is_add_and || (dec_op == OP_NOT);
      // An op in execute is taken up once, only with a full pipe and nothing in flight.
      detect_ok      = !exec_handled_q && (fill_q == FILL_FULL) &&
                       (mem_state_q == MEM_IDLE) && (bub_q == '0);
      mem_start      = detect_ok && exec_is_mem;
      // Branches wait for a valid fetch so the redirected PC is not lost in a stall.
      br_detect      = detect_ok && exec_is_ctrl && bus.complete_instr;
   end

   // Stage enables by priority: memory access, branch bubbles, fetch stall, normal.
   always_comb begin
      en_fetch     = 1'b0;
      en_update_pc = 1'b0;
      en_decode    = 1'b0;
      en_execute   = 1'b0;
      en_writeback = 1'b0;
      br_taken_c   = 1'b0;
      bypass_1_c   = 1'b0;
      bypass_2_c   = 1'b0;
      if (reset) begin
         en_fetch = 1'b0;
      end else if ((mem_state_q != MEM_IDLE) || mem_start) begin
         en_writeback = (mem_state_q == MEM_READ) && bus.complete_data;
      end else if (br_detect || (bub_q != '0)) begin
         en_fetch     = 1'b1;
         en_update_pc = 1'b1;
         br_taken_c   = br_detect &&
                        ((exec_op == OP_JMP) || (|(bus.IR_exec[11:9] & bus.nzp)));
      end else if (!bus.complete_instr) begin
         en_writeback = wb_prev_q;
      end else begin
         en_fetch     = 1'b1;
         en_update_pc = 1'b1;
         en_decode    = (fill_q >= FILL_W'(1));
         en_execute   = (fill_q >= FILL_W'(2));
         en_writeback = wb_prev_q;
         bypass_1_c   = exec_is_alu && (fill_q == FILL_FULL) && dec_is_alu &&
                        (bus.IR_exec[11:9] == bus.IR[8:6]);
         bypass_2_c   = exec_is_alu && (fill_q == FILL_FULL) && dec_is_add_and &&
                        !bus.IR[5] && (bus.IR_exec[11:9] == bus.IR[2:0]);
      end
   end

   // Controller state: fill counter, bubble counter, handled flag and memory FSM.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_state_q    <= MEM_IDLE;
         fill_q         <= '0;
         bub_q          <= '0;
         exec_handled_q <= 1'b0;
         wb_prev_q      <= 1'b0;
         ind_load_q     <= 1'b0;
      end else begin
         wb_prev_q <= en_execute;

         if (en_fetch && bus.complete_instr && (fill_q != FILL_FULL))
            fill_q <= fill_q + FILL_W'(1);

         if (mem_start || br_detect)
            exec_handled_q <= 1'b1;
         else if (en_execute)
            exec_handled_q <= 1'b0;

         if (br_detect)
            bub_q <= BUB_LOAD;
         else if (bub_q != '0)
            bub_q <= bub_q - BUB_W'(1);

         // complete_data is only honoured once the access has actually started.
         case (mem_state_q)
            MEM_IDLE: begin
               if (mem_start) begin
                  ind_load_q <= (exec_op == OP_LDI);
                  if ((exec_op == OP_LD) || (exec_op == OP_LDR))
                     mem_state_q <= MEM_READ;
                  else if ((exec_op == OP_ST) || (exec_op == OP_STR))
                     mem_state_q <= MEM_WRITE;
                  else
                     mem_state_q <= MEM_IND;
               end
            end
            MEM_IND: begin
               if (bus.complete_data)
                  mem_state_q <= ind_load_q ? MEM_READ : MEM_WRITE;
            end
            MEM_READ, MEM_WRITE: begin
               if (bus.complete_data)
                  mem_state_q <= MEM_IDLE;
            end
            default: mem_state_q <= MEM_IDLE;
         endcase
      end
   end

   assign bus.enable_fetch     = en_fetch;
   assign bus.enable_updatePC  = en_update_pc;
   assign bus.enable_decode    = en_decode;
   assign bus.enable_execute   = en_execute;
   assign bus.enable_writeback = en_writeback;
   assign bus.mem_state        = mem_state_q;
   assign bus.br_taken         = br_taken_c;
   assign bus.bypass_alu_1     = bypass_1_c;
   assign bus.bypass_alu_2     = bypass_2_c;

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed bench for lc3_pipe_ctrl: one vector per clock cycle, outputs packed as
// {fetch, updatePC, decode, execute, writeback, mem_state[1:0], br_taken, bypass1, bypass2}.
module tb_lc3_pipe_ctrl;

   typedef struct {
      logic        rst;
      logic [15:0] ir;
      logic [15:0] ire;
      logic [2:0]  nzp;
      logic        ci;
      logic        cd;
      logic [9:0]  exp;
   } vec_t;

   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   wb_pulses;
   vec_t vq[$];
   vec_t v;
   logic [9:0] obs;

   lc3_pipe_ctrl_if bus ();

   lc3_pipe_ctrl #(.BR_BUBBLES(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign obs = {bus.enable_fetch, bus.enable_updatePC, bus.enable_decode,
                 bus.enable_execute, bus.enable_writeback, bus.mem_state,
                 bus.br_taken, bus.bypass_alu_1, bus.bypass_alu_2};

   task automatic add(input logic rst, input logic [15:0] ir, input logic [15:0] ire,
                      input logic [2:0] nzp, input logic ci, input logic cd,
                      input logic [4:0] en, input logic [1:0] ms,
                      input logic br, input logic bp1, input logic bp2);
      vec_t t;
      t.rst = rst; t.ir = ir; t.ire = ire; t.nzp = nzp; t.ci = ci; t.cd = cd;
      t.exp = {en, ms, br, bp1, bp2};
      vq.push_back(t);
   endtask

   // Drive one cycle's inputs (just after a posedge), sample before the next posedge.
   task automatic run_vec(input vec_t t, input string name, input logic do_check);
      reset              = t.rst;
      bus.IR             = t.ir;
      bus.IR_exec        = t.ire;
      bus.nzp            = t.nzp;
      bus.complete_instr = t.ci;
      bus.complete_data  = t.cd;
      #3;
      if (do_check) begin
         n_checks++;
         if (obs !== t.exp) begin
            n_fail++;
            $display("FAIL %s: got f/u/d/e/w=%b ms=%0d br=%b bp=%b%b, expected f/u/d/e/w=%b ms=%0d br=%b bp=%b%b",
                     name, obs[9:5], obs[4:3], obs[2], obs[1], obs[0],
                     t.exp[9:5], t.exp[4:3], t.exp[2], t.exp[1], t.exp[0]);
         end
      end
      if (bus.enable_writeback === 1'b1) wb_pulses++;
      @(posedge clock);
      #1;
   endtask

   task automatic step(input logic rst, input logic [15:0] ir, input logic [15:0] ire,
                       input logic [2:0] nzp, input logic ci, input logic cd,
                       input logic [4:0] en, input logic [1:0] ms,
                       input logic br, input logic bp1, input logic bp2,
                       input string name, input logic do_check);
      vec_t t;
      t.rst = rst; t.ir = ir; t.ire = ire; t.nzp = nzp; t.ci = ci; t.cd = cd;
      t.exp = {en, ms, br, bp1, bp2};
      run_vec(t, name, do_check);
   endtask

   initial begin
      reset              = 1'b1;
      bus.IR             = 16'h0000;
      bus.IR_exec        = 16'h1283;
      bus.nzp            = 3'b000;
      bus.complete_instr = 1'b0;
      bus.complete_data  = 1'b0;
      wb_pulses          = 0;
      repeat (2) @(posedge clock);
      #1;

      //   rst ir       ire      nzp     ci cd  f u d e w   ms    br bp1 bp2
      add(1, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b00000, 2'd3, 0, 0, 0); // 0 reset
      add(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11000, 2'd3, 0, 0, 0); // 1 fill
      add(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11100, 2'd3, 0, 0, 0); // 2
      add(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11110, 2'd3, 0, 0, 0); // 3
      add(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11111, 2'd3, 0, 0, 0); // 4
      add(0, 16'h1841, 16'h1283, 3'b000, 1, 0, 5'b11111, 2'd3, 0, 1, 1); // 5 bypass both
      add(0, 16'h1861, 16'h1283, 3'b000, 1, 0, 5'b11111, 2'd3, 0, 1, 0); // 6 immediate
      add(0, 16'h1881, 16'h1283, 3'b000, 1, 0, 5'b11111, 2'd3, 0, 0, 1); // 7 sr2 only
      add(0, 16'h987F, 16'h1283, 3'b000, 1, 0, 5'b11111, 2'd3, 0, 1, 0); // 8 NOT
      add(0, 16'h1841, 16'h1283, 3'b000, 0, 0, 5'b00001, 2'd3, 0, 0, 0); // 9 stall drain
      add(0, 16'h1841, 16'h1283, 3'b000, 0, 0, 5'b00000, 2'd3, 0, 0, 0); // 10
      add(0, 16'h1841, 16'h1283, 3'b000, 0, 0, 5'b00000, 2'd3, 0, 0, 0); // 11
      add(0, 16'h1841, 16'h1283, 3'b000, 1, 0, 5'b11110, 2'd3, 0, 1, 1); // 12 resume
      add(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11111, 2'd3, 0, 0, 0); // 13
      add(0, 16'h0000, 16'h0405, 3'b010, 1, 0, 5'b11000, 2'd3, 1, 0, 0); // 14 BRz taken
      add(0, 16'h0000, 16'h0405, 3'b010, 1, 0, 5'b11000, 2'd3, 0, 0, 0); // 15 bubble
      add(0, 16'h0000, 16'h0405, 3'b010, 1, 0, 5'b11110, 2'd3, 0, 0, 0); // 16
      add(0, 16'h0000, 16'h0405, 3'b100, 1, 0, 5'b11000, 2'd3, 0, 0, 0); // 17 BRz not taken
      add(0, 16'h0000, 16'h0405, 3'b100, 1, 0, 5'b11000, 2'd3, 0, 0, 0); // 18
      add(0, 16'h0000, 16'h0405, 3'b100, 1, 0, 5'b11110, 2'd3, 0, 0, 0); // 19
      add(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11111, 2'd3, 0, 0, 0); // 20
      add(0, 16'h0000, 16'hC1C0, 3'b000, 0, 0, 5'b00001, 2'd3, 0, 0, 0); // 21 JMP deferred
      add(0, 16'h0000, 16'hC1C0, 3'b000, 1, 0, 5'b11000, 2'd3, 1, 0, 0); // 22 JMP taken
      add(0, 16'h0000, 16'hC1C0, 3'b000, 1, 0, 5'b11000, 2'd3, 0, 0, 0); // 23
      add(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11110, 2'd3, 0, 0, 0); // 24
      add(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11111, 2'd3, 0, 0, 0); // 25
      add(0, 16'h0000, 16'h3000, 3'b000, 1, 1, 5'b00000, 2'd3, 0, 0, 0); // 26 ST entry, cd ignored
      add(0, 16'h0000, 16'h3000, 3'b000, 1, 0, 5'b00000, 2'd2, 0, 0, 0); // 27
      add(0, 16'h0000, 16'h3000, 3'b000, 1, 1, 5'b00000, 2'd2, 0, 0, 0); // 28
      add(0, 16'h0000, 16'h3000, 3'b000, 1, 0, 5'b11110, 2'd3, 0, 0, 0); // 29
      add(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11111, 2'd3, 0, 0, 0); // 30
      add(0, 16'h0000, 16'h2000, 3'b000, 0, 0, 5'b00000, 2'd3, 0, 0, 0); // 31 LD wins over stall
      add(0, 16'h0000, 16'h2000, 3'b000, 0, 0, 5'b00000, 2'd0, 0, 0, 0); // 32
      add(0, 16'h0000, 16'h2000, 3'b000, 0, 1, 5'b00001, 2'd0, 0, 0, 0); // 33 load writeback
      add(0, 16'h0000, 16'h2000, 3'b000, 1, 0, 5'b11110, 2'd3, 0, 0, 0); // 34
      add(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11111, 2'd3, 0, 0, 0); // 35

      foreach (vq[i]) begin
         v = vq[i];
         run_vec(v, $sformatf("vec%0d", i), 1'b1);
      end

      // LDI: data pulses at entry+3 and entry+6, mem_state 3->1->0->3.
      wb_pulses = 0;
      for (int k = 0; k < 8; k++) begin
         logic [1:0] ms_exp;
         logic [4:0] en_exp;
         logic       cd;
         cd     = (k == 3) || (k == 6);
         ms_exp = (k == 0) ? 2'd3 : (k <= 3) ? 2'd1 : (k <= 6) ? 2'd0 : 2'd3;
         en_exp = (k == 6) ? 5'b00001 : (k == 7) ? 5'b11110 : 5'b00000;
         step(0, 16'h0000, 16'hA200, 3'b000, 1, cd, en_exp, ms_exp, 0, 0, 0,
              $sformatf("ldi_k%0d", k), 1'b1);
      end
      n_checks++;
      if (wb_pulses != 1) begin
         n_fail++;
         $display("FAIL ldi_wb_pulses: got %0d, expected 1", wb_pulses);
      end

      // Reset in the middle of an STI indirect access.
      step(0, 16'h0000, 16'hB200, 3'b000, 1, 0, 5'b00000, 2'd3, 0, 0, 0, "sti_entry", 1'b1);
      step(0, 16'h0000, 16'hB200, 3'b000, 1, 0, 5'b00000, 2'd1, 0, 0, 0, "sti_ind", 1'b1);
      step(1, 16'h0000, 16'hB200, 3'b000, 1, 0, 5'b00000, 2'd1, 0, 0, 0, "sti_rst_edge", 1'b0);
      step(1, 16'h0000, 16'hB200, 3'b000, 1, 0, 5'b00000, 2'd3, 0, 0, 0, "sti_after_rst", 1'b1);
      step(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11000, 2'd3, 0, 0, 0, "refill_1", 1'b1);
      step(0, 16'h0000, 16'h1283, 3'b000, 1, 0, 5'b11100, 2'd3, 0, 0, 0, "refill_2", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
